riscv_rf_wb_scheduler: RTL and testbench

//  Shares the two register-file write ports (A, B) among N_REQ writeback requesters
//  (ALU, LSU, MULT, FPU, ...). Grants up to two writes per cycle using round-robin

---
 rtl/riscv_rf_wb_scheduler.sv | 151 +++++++++++++++
 tb/tb_riscv_rf_wb_scheduler.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_rf_wb_scheduler.sv
// riscv_rf_wb_scheduler
//   Shares the two register-file write ports (A, B) among N_REQ writeback requesters.
//   Up to two writes are granted per cycle. Starving requesters go first, lowest index first.
//   The remaining requesters follow in round-robin order starting at rr_ptr. Port B never
//   carries the same register address as port A. Writes to x0 (addr 0) are accepted at once,
//   use no port and produce no write enable.
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid_i/req_ready_o   per-requester handshake (ready is combinational)
//   req_addr_i, req_data_i    packed per-requester address/data, requester 0 at the LSB
//   we/waddr/wdata_{a,b}_o    registered register-file write ports
//   starve_o                  requester wait counter has reached MAX_WAIT
module riscv_rf_wb_scheduler #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_WAIT   = 7
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid_i,
  output logic [N_REQ-1:0]            req_ready_o,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic                        we_a_o,
  output logic [ADDR_WIDTH-1:0]       waddr_a_o,
  output logic [DATA_WIDTH-1:0]       wdata_a_o,
  output logic                        we_b_o,
  output logic [ADDR_WIDTH-1:0]       waddr_b_o,
  output logic [DATA_WIDTH-1:0]       wdata_b_o,
  output logic [N_REQ-1:0]            starve_o
);

  localparam int unsigned PTR_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d, rr_idx;
  logic [CNT_W-1:0]      wait_cnt_q [N_REQ];
  logic [ADDR_WIDTH-1:0] addr [N_REQ];
  logic [DATA_WIDTH-1:0] data [N_REQ];
  logic [N_REQ-1:0]      cand, starving;
  logic                  a_found, b_found;
  logic [PTR_W-1:0]      a_idx, b_idx;
  logic [ADDR_WIDTH-1:0] a_addr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(N_REQ - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      addr[i]     = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
      data[i]     = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      // x0 writes never compete for a port.
      cand[i]     = req_valid_i[i] && (addr[i] != '0);
      starving[i] = cand[i] && (wait_cnt_q[i] == CNT_W'(MAX_WAIT));
      starve_o[i] = (wait_cnt_q[i] == CNT_W'(MAX_WAIT));
    end
  end

  // Walk candidates in priority order: starving first, then round-robin from rr_ptr.
  // The first candidate takes port A, the next one with a different address takes port B.
  always_comb begin
    a_found = 1'b0;
    b_found = 1'b0;
    a_idx   = '0;
    b_idx   = '0;
    a_addr  = '0;
    rr_idx  = rr_ptr_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (starving[i]) begin
        if (!a_found) begin
          a_found = 1'b1;
          a_idx   = PTR_W'(i);
          a_addr  = addr[i];
        end else if (!b_found && (addr[i] != a_addr)) begin
          b_found = 1'b1;
          b_idx   = PTR_W'(i);
        end
      end
    end
    for (int k = 0; k < N_REQ; k++) begin
      if (cand[rr_idx] && !starving[rr_idx]) begin
        if (!a_found) begin
          a_found = 1'b1;
          a_idx   = rr_idx;
          a_addr  = addr[rr_idx];
        end else if (!b_found && (addr[rr_idx] != a_addr)) begin
          b_found = 1'b1;
          b_idx   = rr_idx;
        end
      end
      rr_idx = ptr_inc(rr_idx);
    end
  end

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      req_ready_o[i] = !rst && req_valid_i[i] &&
                       ((addr[i] == '0) ||
                        (a_found && (a_idx == PTR_W'(i))) ||
                        (b_found && (b_idx == PTR_W'(i))));
    end
  end

  // Port B always holds the later-ordered grant, so it defines the next rr start.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (b_found) begin
      rr_ptr_d = ptr_inc(b_idx);
    end else if (a_found) begin
      rr_ptr_d = ptr_inc(a_idx);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q  <= '0;
      we_a_o    <= 1'b0;
      waddr_a_o <= '0;
      wdata_a_o <= '0;
      we_b_o    <= 1'b0;
      waddr_b_o <= '0;
      wdata_b_o <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        wait_cnt_q[i] <= '0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      we_a_o   <= a_found;
      we_b_o   <= b_found;
      if (a_found) begin
        waddr_a_o <= addr[a_idx];
        wdata_a_o <= data[a_idx];
      end
      if (b_found) begin
        waddr_b_o <= addr[b_idx];
        wdata_b_o <= data[b_idx];
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (!req_valid_i[i] || req_ready_o[i]) begin
          wait_cnt_q[i] <= '0;
        end else if (wait_cnt_q[i] != CNT_W'(MAX_WAIT)) begin
          wait_cnt_q[i] <= wait_cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_riscv_rf_wb_scheduler.sv
module tb_riscv_rf_wb_scheduler;
  localparam int N  = 4;
  localparam int AW = 6;
  localparam int DW = 32;
  localparam int MW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0]    valid;
  logic [AW-1:0]   addr [N];
  logic [DW-1:0]   data [N];
  logic [N*AW-1:0] addr_bus;
  logic [N*DW-1:0] data_bus;

  logic [N-1:0]  req_ready_o, starve_o;
  logic          we_a_o, we_b_o;
  logic [AW-1:0] waddr_a_o, waddr_b_o;
  logic [DW-1:0] wdata_a_o, wdata_b_o;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      addr_bus[i*AW +: AW] = addr[i];
      data_bus[i*DW +: DW] = data[i];
    end
  end

  riscv_rf_wb_scheduler #(
    .N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(valid), .req_ready_o(req_ready_o),
    .req_addr_i(addr_bus), .req_data_i(data_bus),
    .we_a_o(we_a_o), .waddr_a_o(waddr_a_o), .wdata_a_o(wdata_a_o),
    .we_b_o(we_b_o), .waddr_b_o(waddr_b_o), .wdata_b_o(wdata_b_o),
    .starve_o(starve_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: committed state (m_*), next state staged at negedge (s_*).
  int            m_rr, s_rr;
  int            m_cnt [N];
  int            s_cnt [N];
  logic          m_we_a, m_we_b, s_we_a, s_we_b;
  logic [AW-1:0] m_wa_a, m_wa_b, s_wa_a, s_wa_b;
  logic [DW-1:0] m_wd_a, m_wd_b, s_wd_a, s_wd_b;
  logic [N-1:0]  hs;

  task automatic model_reset();
    m_rr = 0; s_rr = 0;
    m_we_a = 0; m_we_b = 0; m_wa_a = '0; m_wa_b = '0; m_wd_a = '0; m_wd_b = '0;
    s_we_a = 0; s_we_b = 0; s_wa_a = '0; s_wa_b = '0; s_wd_a = '0; s_wd_b = '0;
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0;
      s_cnt[i] = 0;
    end
    hs = '0;
  endtask

  initial begin
    int           order [$];
    int           pa, pb, j;
    logic [N-1:0] exp_rdy, exp_stv;
    model_reset();
    forever begin
      @(negedge clk);
      if (rst) begin
        model_reset();
        chk("rst_ready", req_ready_o, '0);
        chk("rst_we_a", we_a_o, 1'b0);
        chk("rst_we_b", we_b_o, 1'b0);
      end else begin
        order.delete();
        for (int i = 0; i < N; i++)
          if (valid[i] && addr[i] != 0 && m_cnt[i] == MW) order.push_back(i);
        for (int k = 0; k < N; k++) begin
          j = (m_rr + k) % N;
          if (valid[j] && addr[j] != 0 && m_cnt[j] != MW) order.push_back(j);
        end
        pa = -1;
        pb = -1;
        if (order.size() > 0) pa = order[0];
        for (int q = 1; q < order.size(); q++)
          if (pb < 0 && addr[order[q]] != addr[pa]) pb = order[q];
        for (int i = 0; i < N; i++) begin
          exp_rdy[i] = valid[i] && (addr[i] == 0 || i == pa || i == pb);
          exp_stv[i] = (m_cnt[i] == MW);
        end
        chk("ready", req_ready_o, exp_rdy);
        chk("starve", starve_o, exp_stv);
        chk("we_a", we_a_o, m_we_a);
        chk("waddr_a", waddr_a_o, m_wa_a);
        chk("wdata_a", wdata_a_o, m_wd_a);
        chk("we_b", we_b_o, m_we_b);
        chk("waddr_b", waddr_b_o, m_wa_b);
        chk("wdata_b", wdata_b_o, m_wd_b);
        for (int i = 0; i < N; i++)
          s_cnt[i] = (!valid[i] || exp_rdy[i]) ? 0 : ((m_cnt[i] < MW) ? m_cnt[i] + 1 : MW);
        s_rr = m_rr;
        if (pb >= 0) s_rr = (pb + 1) % N;
        else if (pa >= 0) s_rr = (pa + 1) % N;
        s_we_a = (pa >= 0);
        s_we_b = (pb >= 0);
        s_wa_a = m_wa_a; s_wd_a = m_wd_a; s_wa_b = m_wa_b; s_wd_b = m_wd_b;
        if (pa >= 0) begin s_wa_a = addr[pa]; s_wd_a = data[pa]; end
        if (pb >= 0) begin s_wa_b = addr[pb]; s_wd_b = data[pb]; end
        hs = exp_rdy;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      if (!rst) begin
        m_rr = s_rr;
        m_cnt = s_cnt;
        m_we_a = s_we_a; m_wa_a = s_wa_a; m_wd_a = s_wd_a;
        m_we_b = s_we_b; m_wa_b = s_wa_b; m_wd_b = s_wd_b;
      end
    end
  end

  // Requesters stay valid and present fresh data after each accept.
  task automatic cycle_keep();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (hs[i]) data[i] = data[i] + 1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    valid = '0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 7) return AW'(32);
    if (r == 8) return AW'(33);
    if (r == 9) return AW'($urandom_range(0, 63));
    return AW'(r);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] da, db;
    valid = '1;
    for (int i = 0; i < N; i++) begin
      addr[i] = AW'(i + 1);
      data[i] = DW'(32'hA000 + i * 16);
    end

    // T1: reset with all valid
    repeat (2) @(negedge clk);
    #1;
    chk("t1_ready_in_reset", req_ready_o, 4'b0000);
    chk("t1_we_a_in_reset", we_a_o, 1'b0);
    chk("t1_we_b_in_reset", we_b_o, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("t1_first_grant", req_ready_o, 4'b0011);

    // T2: round-robin over addrs 1..4
    da = data[0]; db = data[1];
    cycle_keep();
    chk("t2_c0_we_a", we_a_o, 1'b1);
    chk("t2_c0_waddr_a", waddr_a_o, 6'd1);
    chk("t2_c0_wdata_a", wdata_a_o, da);
    chk("t2_c0_we_b", we_b_o, 1'b1);
    chk("t2_c0_waddr_b", waddr_b_o, 6'd2);
    chk("t2_c0_wdata_b", wdata_b_o, db);
    @(negedge clk);
    #1;
    chk("t2_c1_ready", req_ready_o, 4'b1100);
    da = data[2]; db = data[3];
    cycle_keep();
    chk("t2_c1_waddr_a", waddr_a_o, 6'd3);
    chk("t2_c1_wdata_a", wdata_a_o, da);
    chk("t2_c1_waddr_b", waddr_b_o, 6'd4);
    chk("t2_c1_wdata_b", wdata_b_o, db);
    @(negedge clk);
    #1;
    chk("t2_c2_ready", req_ready_o, 4'b0011);

    // T3: same-address conflict
    do_reset();
    valid = 4'b0111;
    addr[0] = 6'd5; addr[1] = 6'd5; addr[2] = 6'd6;
    data[0] = 32'h3000; data[1] = 32'h3001; data[2] = 32'h3002;
    @(negedge clk);
    #1;
    chk("t3_ready", req_ready_o, 4'b0101);
    @(posedge clk);
    #1;
    chk("t3_waddr_a", waddr_a_o, 6'd5);
    chk("t3_wdata_a", wdata_a_o, 32'h3000);
    chk("t3_waddr_b", waddr_b_o, 6'd6);
    valid = 4'b0010;
    @(negedge clk);
    #1;
    chk("t3_skipped_ready", req_ready_o, 4'b0010);
    @(posedge clk);
    #1;
    chk("t3_late_we_a", we_a_o, 1'b1);
    chk("t3_late_wdata_a", wdata_a_o, 32'h3001);
    chk("t3_late_we_b", we_b_o, 1'b0);

    // T4: x0 write consumes no port
    valid = 4'b0111;
    addr[0] = 6'd9; addr[1] = 6'd0; addr[2] = 6'd10;
    data[0] = 32'h4000; data[1] = 32'hDEAD; data[2] = 32'h4002;
    @(negedge clk);
    #1;
    chk("t4_ready", req_ready_o, 4'b0111);
    @(posedge clk);
    #1;
    valid = '0;
    chk("t4_waddr_a", waddr_a_o, 6'd10);
    chk("t4_waddr_b", waddr_b_o, 6'd9);
    chk("t4_wdata_b", wdata_b_o, 32'h4000);

    // T5: req3 loses three cycles to conflicts, then wins via starvation
    do_reset();
    valid = '1;
    addr[0] = 6'd8; addr[1] = 6'd7; addr[2] = 6'd7; addr[3] = 6'd7;
    for (int i = 0; i < N; i++) data[i] = DW'(32'h5000 + i);
    @(negedge clk);
    #1;
    chk("t5_c0_ready", req_ready_o, 4'b0011);
    cycle_keep();
    @(negedge clk);
    #1;
    chk("t5_c1_ready", req_ready_o, 4'b0101);
    cycle_keep();
    @(negedge clk);
    #1;
    chk("t5_c2_ready", req_ready_o, 4'b0011);
    chk("t5_c2_starve", starve_o, 4'b0000);
    cycle_keep();
    @(negedge clk);
    #1;
    chk("t5_c3_starve", starve_o, 4'b1000);
    chk("t5_c3_ready", req_ready_o, 4'b1001);
    da = data[3];
    cycle_keep();
    chk("t5_c3_we_a", we_a_o, 1'b1);
    chk("t5_c3_wdata_a", wdata_a_o, da);

    // T6: asynchronous reset between edges while a write is out
    #1;
    rst = 1'b1;
    #1;
    chk("t6_we_a_drop", we_a_o, 1'b0);
    chk("t6_we_b_drop", we_b_o, 1'b0);
    chk("t6_waddr_a_clr", waddr_a_o, 6'd0);
    chk("t6_starve_clr", starve_o, 4'b0000);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("t6_no_we_after_release", we_a_o, 1'b0);
    chk("t6_rr_restart", req_ready_o, 4'b0011);

    // Random phase
    repeat (4000) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (hs[i] || !valid[i]) begin
          if ($urandom_range(0, 99) < 60) begin
            valid[i] = 1'b1;
            addr[i] = rand_addr();
            data[i] = DW'($urandom);
          end else begin
            valid[i] = 1'b0;
          end
        end
      end
    end
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
